// File: rtl/r2mdc_delay_commutator.sv
// r2mdc_delay_commutator: R2MDC stage-boundary delay commutator (pre-delay, switch, post-delay)
module r2mdc_delay_commutator #(
  parameter int DATA_W = 16,
  parameter int DELAY  = 16,
  parameter int MODE   = 0
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              in_valid,
  input  logic              in_sync,
  input  logic [DATA_W-1:0] in0_re,
  input  logic [DATA_W-1:0] in0_im,
  input  logic [DATA_W-1:0] in1_re,
  input  logic [DATA_W-1:0] in1_im,
  output logic              out_valid,
  output logic              out_sync,
  output logic [DATA_W-1:0] out0_re,
  output logic [DATA_W-1:0] out0_im,
  output logic [DATA_W-1:0] out1_re,
  output logic [DATA_W-1:0] out1_im
);
  localparam int LW = $clog2(DELAY);
  localparam int AW = (LW > 0) ? LW : 1;
  localparam int W  = 2 * DATA_W;
  logic [LW:0]   r_cnt;
  logic [LW:0]   w_n;
  logic          r_fill;
  logic [AW-1:0] w_ptr;
  logic          w_ph;
  logic          w_vld;
  logic          w_first;
  logic [W-1:0]  w_a;
  logic [W-1:0]  w_b;
  logic [W-1:0]  w_x0;
  logic [W-1:0]  w_x1;
  logic [W-1:0]  w_xd;
  logic [W-1:0]  r_xd [DELAY];
  assign w_a = {in0_re, in0_im};
  assign w_b = {in1_re, in1_im};
  assign w_n = in_sync ? '0 : r_cnt;
  assign w_ph = w_n[LW];
  // Before fill, the phase bit first rises exactly at n == DELAY
  assign w_vld = !in_sync && (r_fill || w_ph);
  assign w_first = w_vld && !r_fill;
  generate
    if (DELAY == 1) begin : g_ptr1
      assign w_ptr = '0;
    end else begin : g_ptrn
      assign w_ptr = w_n[AW-1:0];
    end
    if (MODE == 0) begin : g_full
      logic [W-1:0] r_bd [DELAY];
      logic [W-1:0] w_bd;
      assign w_bd = r_bd[w_ptr];
      assign w_x0 = w_ph ? w_bd : w_a;
      assign w_x1 = w_ph ? w_a : w_bd;
      always_ff @(posedge CLK) begin
        if (in_valid) r_bd[w_ptr] <= w_b;
      end
    end else begin : g_post
      assign w_x0 = w_a;
      assign w_x1 = w_b;
    end
  endgenerate
  assign w_xd = r_xd[w_ptr];
  always_ff @(posedge CLK) begin
    if (in_valid) r_xd[w_ptr] <= w_x0;
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_cnt     <= '0;
      r_fill    <= 1'b0;
      out_valid <= 1'b0;
      out_sync  <= 1'b0;
      out0_re   <= '0;
      out0_im   <= '0;
      out1_re   <= '0;
      out1_im   <= '0;
    end else begin
      out_valid <= in_valid && w_vld;
      out_sync  <= in_valid && w_first;
      if (in_valid) begin
        r_cnt              <= w_n + 1'b1;
        r_fill             <= w_vld;
        {out0_re, out0_im} <= w_xd;
        {out1_re, out1_im} <= w_x1;
      end
    end
  end
endmodule

// File: tb/tb_r2mdc_delay_commutator.sv
// tb_r2mdc_delay_commutator: directed checks of full mode (DELAY 1 and 4) and post-only mode
module tb_r2mdc_delay_commutator;
  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_sync = 1'b0;
  logic [15:0] a_re = '0, a_im = '0, b_re = '0, b_im = '0;
  logic        v4, s4, v1, s1, vp, sp;
  logic [15:0] o4_0r, o4_0i, o4_1r, o4_1i;
  logic [15:0] o1_0r, o1_0i, o1_1r, o1_1i;
  logic [15:0] op_0r, op_0i, op_1r, op_1i;
  int n_asrt = 0;
  int n_fail = 0;
  always #5 CLK = ~CLK;
  r2mdc_delay_commutator #(.DATA_W(16), .DELAY(4), .MODE(0)) u_d4 (
    .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_sync(in_sync),
    .in0_re(a_re), .in0_im(a_im), .in1_re(b_re), .in1_im(b_im),
    .out_valid(v4), .out_sync(s4),
    .out0_re(o4_0r), .out0_im(o4_0i), .out1_re(o4_1r), .out1_im(o4_1i));
  r2mdc_delay_commutator #(.DATA_W(16), .DELAY(1), .MODE(0)) u_d1 (
    .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_sync(in_sync),
    .in0_re(a_re), .in0_im(a_im), .in1_re(b_re), .in1_im(b_im),
    .out_valid(v1), .out_sync(s1),
    .out0_re(o1_0r), .out0_im(o1_0i), .out1_re(o1_1r), .out1_im(o1_1i));
  r2mdc_delay_commutator #(.DATA_W(16), .DELAY(4), .MODE(1)) u_dp (
    .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_sync(in_sync),
    .in0_re(a_re), .in0_im(a_im), .in1_re(b_re), .in1_im(b_im),
    .out_valid(vp), .out_sync(sp),
    .out0_re(op_0r), .out0_im(op_0i), .out1_re(op_1r), .out1_im(op_1i));
  task automatic chk(input string tag, input int obs, input int exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask
  task automatic step(input bit v, input bit s, input int av, input int bv);
    in_valid = v;
    in_sync  = s;
    a_re = 16'(av);
    a_im = 16'(av) ^ 16'hA5A5;
    b_re = 16'(bv);
    b_im = 16'(bv) ^ 16'hA5A5;
    @(posedge CLK);
    #1;
  endtask
  task automatic chk_pair(input string tag, input int r0, input int i0, input int r1, input int i1,
                          input int e0, input int e1);
    chk({tag, "_out0_re"}, r0, e0);
    chk({tag, "_out0_im"}, i0, e0 ^ 'hA5A5);
    chk({tag, "_out1_re"}, r1, e1);
    chk({tag, "_out1_im"}, i1, e1 ^ 'hA5A5);
  endtask
  // n = beat index in frame, off = value offset of the frame's a/b streams
  task automatic check_all(input int n, input bit idle, input int off);
    int e0, e1;
    chk("d4_valid", int'(v4), int'(!idle && n >= 4));
    chk("d4_sync", int'(s4), int'(!idle && n == 4));
    if (n >= 4) begin
      if ((n / 4) % 2 == 1) begin e0 = n - 4; e1 = n; end
      else begin e0 = 100 + n - 8; e1 = 100 + n - 4; end
      chk_pair("d4", o4_0r, o4_0i, o4_1r, o4_1i, e0 + off, e1 + off);
    end
    chk("d1_valid", int'(v1), int'(!idle && n >= 1));
    chk("d1_sync", int'(s1), int'(!idle && n == 1));
    if (n >= 1) begin
      if (n % 2 == 1) begin e0 = n - 1; e1 = n; end
      else begin e0 = 100 + n - 2; e1 = 100 + n - 1; end
      chk_pair("d1", o1_0r, o1_0i, o1_1r, o1_1i, e0 + off, e1 + off);
    end
    chk("dp_valid", int'(vp), int'(!idle && n >= 4));
    chk("dp_sync", int'(sp), int'(!idle && n == 4));
    if (n >= 4) chk_pair("dp", op_0r, op_0i, op_1r, op_1i, n - 4 + off, 100 + n + off);
  endtask
  initial begin
    step(0, 0, 0, 0);
    step(1, 1, 55, 66);
    chk("rst_valid", int'({v4, v1, vp}), 0);
    chk("rst_sync", int'({s4, s1, sp}), 0);
    chk_pair("rst_d4", o4_0r, o4_0i ^ 'hA5A5, o4_1r, o4_1i ^ 'hA5A5, 0, 0);
    chk_pair("rst_dp", op_0r, op_0i ^ 'hA5A5, op_1r, op_1i ^ 'hA5A5, 0, 0);
    RST = 1'b0;
    for (int n = 0; n < 16; n++) begin
      step(1, n == 0, n, 100 + n);
      check_all(n, 0, 0);
    end
    for (int n = 0; n < 16; n++) begin
      step(1, n == 0, n, 100 + n);
      check_all(n, 0, 0);
      step(0, 0, 999, 999);
      check_all(n, 1, 0);
    end
    for (int n = 0; n < 6; n++) step(1, n == 0, n, 100 + n);
    RST = 1'b1;
    step(1, 0, 6, 106);
    RST = 1'b0;
    chk("midrst_valid", int'({v4, v1, vp}), 0);
    chk("midrst_sync", int'({s4, s1, sp}), 0);
    for (int n = 0; n < 10; n++) begin
      step(1, 0, n, 100 + n);
      check_all(n, 0, 0);
    end
    for (int k = 0; k < 8; k++) begin
      step(1, k == 0, 10 + k, 110 + k);
      check_all(k, 0, 10);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end
endmodule
